keypad_scanner: RTL and testbench

Matrix-keypad front end that is the device-side counterpart of the external 4x4 keypad on `key_out_x`/`key_in_y`. It drives the columns one at a time, samples the rows, debounces whole scan frames and delivers one 4-bit key code per press to the CPU core over a valid/ack handshake. It sits between the board pins and the CPU input port logic in `my_cpu`.

---
 rtl/keypad_scanner_pkg.sv | 6 +
 rtl/keypad_scanner_sync2.sv | 12 +
 rtl/keypad_scanner.sv | 102 ++++++++++
 tb/tb_keypad_scanner.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// keypad_scanner_pkg: default timing constants and debounce state encoding
package keypad_scanner_pkg;
  localparam int SCAN_DIV_DEF = 50000;
  localparam int DEBOUNCE_CNT_DEF = 4;
  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;
endpackage

// File: rtl/keypad_scanner_sync2.sv
// sync2: 4-bit two-flop synchronizer, resets to all ones (rows idle high)
module sync2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);
  logic [3:0] m;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, m} <= '1;
    else {q, m} <= {m, d};
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix scan, frame debounce and valid/ack key delivery
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV     = SCAN_DIV_DEF,
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_in_y,
  output logic [3:0] key_out_x,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_down,
  output logic       key_ovr
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [3:0] DB = 4'(DEBOUNCE_CNT);
  logic [3:0] rows_s, k, cnt, cnt_nx, cnt_inc, cand, cand_nx;
  logic [DW-1:0] div_cnt;
  logic [1:0] col;
  logic [15:0] frame, frame_nx;
  logic tick, done, single, hit, accept;
  state_t state, state_nx;
  sync2 u_sync (.clk(clk), .rst_n(rst_n), .d(key_in_y), .q(rows_s));
  assign tick = div_cnt == DIV_MAX;
  assign done = tick && col == 2'd3;
  assign key_out_x = ~(4'b0001 << col);
  assign key_down = state == HELD || state == RELEASE_DB;
  assign single = $onehot(frame_nx);
  assign hit = single && k == cand;
  assign cnt_inc = cnt + 4'd1;
  // frame as it will look after this tick, so the last column is classified too
  always_comb begin
    frame_nx = frame;
    frame_nx[{col, 2'b00} +: 4] = ~rows_s;
    k = '0;
    for (int i = 0; i < 16; i++) if (frame_nx[i]) k = 4'(i);
  end
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    cand_nx = cand;
    accept = 1'b0;
    if (done)
      case (state)
        IDLE: if (single) begin
          cand_nx = k;
          cnt_nx = 4'd1;
          accept = DB == 4'd1;
          state_nx = DB == 4'd1 ? HELD : PRESS_DB;
        end
        PRESS_DB:
          if (hit) begin
            cnt_nx = cnt_inc;
            accept = cnt_inc == DB;
            state_nx = cnt_inc == DB ? HELD : PRESS_DB;
          end else if (single) begin
            cand_nx = k;
            cnt_nx = 4'd1;
          end else state_nx = IDLE;
        HELD: if (!hit) begin
          cnt_nx = 4'd1;
          state_nx = DB == 4'd1 ? IDLE : RELEASE_DB;
        end
        RELEASE_DB:
          if (hit) state_nx = HELD;
          else begin
            cnt_nx = cnt_inc;
            state_nx = cnt_inc == DB ? IDLE : RELEASE_DB;
          end
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div_cnt <= '0;
      col <= '0;
      frame <= '0;
      state <= IDLE;
      cnt <= '0;
      cand <= '0;
      key_code <= '0;
      key_valid <= 1'b0;
      key_ovr <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (tick) begin
        col <= col + 2'd1;
        frame <= frame_nx;
      end
      state <= state_nx;
      cnt <= cnt_nx;
      cand <= cand_nx;
      // a handshake in the same cycle frees the slot before the new code lands
      if (accept && (!key_valid || key_ack)) key_code <= cand_nx;
      key_valid <= accept || (key_valid && !key_ack);
      key_ovr <= (key_valid && key_ack) ? 1'b0 : key_ovr || (accept && key_valid);
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad emulation with a frame-level press/release model
module tb_keypad_scanner;
  localparam int D = 2;
  logic clk = 1'b0, rst_n = 1'b1, key_ack = 1'b0;
  logic [3:0] key_in_y, key_out_x, key_code;
  logic key_valid, key_down, key_ovr;
  logic [15:0] mask = '0;
  int n_cmp = 0, n_err = 0, edge_n = 0;
  int held, hk, run, last;
  logic m_valid, m_ovr;
  logic [3:0] m_code;
  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(D)) dut (
    .clk(clk), .rst_n(rst_n), .key_in_y(key_in_y), .key_out_x(key_out_x),
    .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack),
    .key_down(key_down), .key_ovr(key_ovr)
  );
  always #5 clk = ~clk;
  // pressed key at (c,r) pulls row r low while column c is driven low
  always_comb begin
    key_in_y = 4'hf;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (mask[c*4+r] && !key_out_x[c]) key_in_y[r] = 1'b0;
  end
  function automatic int classify(input logic [15:0] m);
    if ($countones(m) != 1) return -1;
    for (int i = 0; i < 16; i++) if (m[i]) return i;
    return -1;
  endfunction
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic check_all();
    logic [3:0] ex;
    ex = ~(4'b0001 << ((edge_n / 4) % 4));
    check("key_out_x", 16'(key_out_x), 16'(ex));
    check("key_valid", 16'(key_valid), 16'(m_valid));
    check("key_code", 16'(key_code), 16'(m_code));
    check("key_down", 16'(key_down), 16'(held != 0));
    check("key_ovr", 16'(key_ovr), 16'(m_ovr));
  endtask
  task automatic model_reset();
    held = 0; hk = -1; run = 0; last = -1;
    m_valid = 1'b0; m_ovr = 1'b0; m_code = '0; edge_n = 0;
  endtask
  task automatic deliver(input int s);
    if (m_valid) m_ovr = 1'b1;
    else begin
      m_code = 4'(s);
      m_valid = 1'b1;
    end
  endtask
  // a press needs D identical single-key frames in a row; a release needs D frames without it
  task automatic model_frame(input int s);
    if (held == 0) begin
      if (s < 0) run = 0;
      else if (s == last) run++;
      else run = 1;
      last = s;
      if (s >= 0 && run == D) begin
        deliver(s);
        held = 1; hk = s; run = 0;
      end
    end else begin
      run = (s != hk) ? run + 1 : 0;
      if (run == D) begin
        held = 0; run = 0; last = -1;
      end
    end
  endtask
  task automatic run_frame(input logic [15:0] m, input int ack_at);
    mask = m;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      key_ack = (cyc == ack_at);
      @(posedge clk);
      #1;
      key_ack = 1'b0;
      edge_n++;
      if (cyc == ack_at && m_valid) begin
        m_valid = 1'b0;
        m_ovr = 1'b0;
      end
      if (cyc == 16) model_frame(classify(m));
      check_all();
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    key_ack = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask
  initial begin
    logic [15:0] m;
    int r, ack;
    #2;
    do_reset();
    repeat (4) run_frame(16'h0000, 0);
    check("idle_valid", 16'(key_valid), 16'h0);
    repeat (3) run_frame(16'h0040, 0);
    check("k6_code", 16'(key_code), 16'h6);
    check("k6_valid", 16'(key_valid), 16'h1);
    run_frame(16'h0040, 5);
    check("k6_acked", 16'(key_valid), 16'h0);
    run_frame(16'h0000, 0);
    check("k6_down_1", 16'(key_down), 16'h1);
    run_frame(16'h0000, 0);
    check("k6_down_2", 16'(key_down), 16'h0);
    repeat (3) begin
      run_frame(16'h0040, 0);
      run_frame(16'h0000, 0);
    end
    check("bounce_valid", 16'(key_valid), 16'h0);
    repeat (3) run_frame(16'h0021, 0);
    check("ghost_valid", 16'(key_valid), 16'h0);
    repeat (2) run_frame(16'h0001, 0);
    check("k0_valid", 16'(key_valid), 16'h1);
    check("k0_code", 16'(key_code), 16'h0);
    run_frame(16'h0001, 3);
    repeat (2) run_frame(16'h0000, 0);
    repeat (2) run_frame(16'h0008, 0);
    repeat (2) run_frame(16'h0000, 0);
    repeat (2) run_frame(16'h0200, 0);
    check("ovr_code", 16'(key_code), 16'h3);
    check("ovr_flag", 16'(key_ovr), 16'h1);
    run_frame(16'h0200, 8);
    check("ovr_ack_valid", 16'(key_valid), 16'h0);
    check("ovr_ack_flag", 16'(key_ovr), 16'h0);
    repeat (2) run_frame(16'h0000, 0);
    repeat (2) run_frame(16'h0010, 0);
    repeat (2) run_frame(16'h0000, 0);
    run_frame(16'h0100, 0);
    run_frame(16'h0100, 16);
    check("same_cycle_valid", 16'(key_valid), 16'h1);
    check("same_cycle_code", 16'(key_code), 16'h8);
    check("same_cycle_ovr", 16'(key_ovr), 16'h0);
    run_frame(16'h0000, 2);
    run_frame(16'h0000, 0);
    run_frame(16'h8000, 0);
    mask = 16'h8000;
    repeat (7) @(posedge clk);
    #1;
    do_reset();
    run_frame(16'h8000, 0);
    check("rst_fresh_valid", 16'(key_valid), 16'h0);
    run_frame(16'h8000, 0);
    check("rst_fresh_code", 16'(key_code), 16'hf);
    run_frame(16'h0000, 4);
    run_frame(16'h0000, 0);
    m = '0;
    for (int f = 0; f < 60; f++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) m = m;
      else if (r < 7) m = 16'h0001 << $urandom_range(0, 15);
      else if (r < 8) m = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      else m = '0;
      ack = int'($urandom_range(0, 24));
      run_frame(m, ack > 16 ? 0 : ack);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
